// File: rtl/atd_detector_if.sv
// Signal bundle between the ATD pins and the edge detector.
// The master drives the raw ATD lines; the slave (the detector) returns the strobe and bit.
interface atd_detector_if;
  logic ATD_clk;
  logic ATD_data;
  logic ATD_shift_enable;
  logic ATD_bit;

  modport master (
    output ATD_clk,
    output ATD_data,
    input  ATD_shift_enable,
    input  ATD_bit
  );

  modport slave (
    input  ATD_clk,
    input  ATD_data,
    output ATD_shift_enable,
    output ATD_bit
  );
endinterface

// File: rtl/atd_detector.sv
// ATD link front end: synchronizes ATD_clk/ATD_data, glitch-filters the clock and emits a
// one-cycle shift strobe with the data bit sampled on each qualified rising edge.
module atd_detector #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1
) (
  input  logic          clk,
  input  logic          n_rst,
  atd_detector_if.slave atd
);

  localparam int unsigned CntW = $clog2(FILTER_LEN) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   flt_q;
  logic                   flt_d;
  logic                   shift_en_q;
  logic                   bit_q;
  logic                   sc;
  logic                   sd;
  logic                   rise;

  assign sc = clk_sync_q[SYNC_STAGES-1];
  assign sd = data_sync_q[SYNC_STAGES-1];

  // flt_d is the current filtered level; flt_q is its one-cycle-delayed copy (prev).
  // Using the combinational level keeps FILTER_LEN=1 free of any added latency.
  always_comb begin
    cnt_d = cnt_q;
    flt_d = flt_q;
    if (sc == flt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      flt_d = sc;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = flt_d & ~flt_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      cnt_q       <= '0;
      flt_q       <= 1'b0;
      shift_en_q  <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], atd.ATD_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], atd.ATD_data};
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      shift_en_q  <= rise;
      if (rise) begin
        bit_q <= sd;
      end
    end
  end

  assign atd.ATD_shift_enable = shift_en_q;
  assign atd.ATD_bit          = bit_q;

endmodule

// File: tb/tb_atd_detector.sv
// Scoreboard bench for atd_detector: stimulus queues expected strobes (cycle, bit),
// per-DUT monitors pop and compare whenever a strobe appears.
module tb_atd_detector;

  logic        tb_clk = 1'b0;
  logic        n_rst  = 1'b1;
  int unsigned cyc    = 0;
  int          tests  = 0;
  int          fails  = 0;

  typedef struct {
    int unsigned cyc;
    logic        b;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  atd_detector_if if1 ();
  atd_detector_if if3 ();

  atd_detector #(.SYNC_STAGES(2), .FILTER_LEN(1)) dut1 (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .atd   (if1)
  );

  atd_detector #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut3 (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .atd   (if3)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  // Monitor for FILTER_LEN=1 instance
  always @(negedge tb_clk) begin
    exp_t e;
    if (if1.ATD_shift_enable !== 1'b0) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1 unexpected strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = q1.pop_front();
        cmp("dut1 strobe cycle", cyc, e.cyc);
        cmp("dut1 strobe bit", {31'b0, if1.ATD_bit}, {31'b0, e.b});
      end
    end
  end

  // Monitor for FILTER_LEN=3 instance
  always @(negedge tb_clk) begin
    exp_t e;
    if (if3.ATD_shift_enable !== 1'b0) begin
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut3 unexpected strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = q3.pop_front();
        cmp("dut3 strobe cycle", cyc, e.cyc);
        cmp("dut3 strobe bit", {31'b0, if3.ATD_bit}, {31'b0, e.b});
      end
    end
  end

  initial begin
    if1.ATD_clk  = 1'b1;
    if1.ATD_data = 1'b1;
    if3.ATD_clk  = 1'b0;
    if3.ATD_data = 1'b0;
    n_rst        = 1'b1;

    // Reset held with the ATD lines high: outputs stay zero
    for (int i = 0; i < 3; i++) begin
      @(negedge tb_clk);
      cmp("reset shift_enable", {31'b0, if1.ATD_shift_enable}, 32'd0);
      cmp("reset bit", {31'b0, if1.ATD_bit}, 32'd0);
    end
    n_rst        = 1'b0;
    if1.ATD_clk  = 1'b0;
    if1.ATD_data = 1'b0;
    wait_cyc(5);

    // Rising edge with data 1: strobe after the 3rd clk rising edge
    if1.ATD_data = 1'b1;
    q1.push_back('{cyc + 3, 1'b1});
    if1.ATD_clk = 1'b1;
    wait_cyc(10);
    cmp("bit after first strobe", {31'b0, if1.ATD_bit}, 32'd1);

    // Falling edge: no strobe
    if1.ATD_clk = 1'b0;
    wait_cyc(10);

    // Data capture 0
    if1.ATD_data = 1'b0;
    q1.push_back('{cyc + 3, 1'b0});
    if1.ATD_clk = 1'b1;
    wait_cyc(6);
    cmp("bit holds 0", {31'b0, if1.ATD_bit}, 32'd0);
    if1.ATD_clk = 1'b0;
    wait_cyc(6);

    // Data capture 1, then data changes while clock stays high
    if1.ATD_data = 1'b1;
    q1.push_back('{cyc + 3, 1'b1});
    if1.ATD_clk = 1'b1;
    wait_cyc(6);
    if1.ATD_data = 1'b0;
    wait_cyc(5);
    cmp("bit holds 1 across data change", {31'b0, if1.ATD_bit}, 32'd1);
    if1.ATD_clk = 1'b0;
    wait_cyc(6);

    // Reset on the 2nd clk edge after ATD_clk rises discards the pending edge
    if1.ATD_clk = 1'b1;
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    n_rst       = 1'b0;
    if1.ATD_clk = 1'b0;
    cmp("reset clears bit", {31'b0, if1.ATD_bit}, 32'd0);
    wait_cyc(10);

    // Glitch filter: 2-cycle pulse suppressed
    if3.ATD_data = 1'b1;
    if3.ATD_clk  = 1'b1;
    wait_cyc(2);
    if3.ATD_clk = 1'b0;
    wait_cyc(10);

    // 4-cycle pulse passes, two cycles later than the unfiltered case
    q3.push_back('{cyc + 5, 1'b1});
    if3.ATD_clk = 1'b1;
    wait_cyc(4);
    if3.ATD_clk = 1'b0;
    wait_cyc(12);

    cmp("dut1 missing strobes", q1.size(), 32'd0);
    cmp("dut3 missing strobes", q3.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
